// File: rtl/button_debounce.sv
// button_debounce
//   Four independent push-button debouncers with edge pulses, LED toggles
//   and a shared press counter.
//
//   State table (one FSM per channel):
//     state   | meaning
//     IDLE_LO | accepted level is 0, waiting for s2 to go high
//     DEB_HI  | s2 high, counting toward acceptance of a 1
//     IDLE_HI | accepted level is 1, waiting for s2 to go low
//     DEB_LO  | s2 low, counting toward acceptance of a 0
//
//   Parameters
//     DB_CYCLES  consecutive synchronized cycles a new level must hold (1..2^CNT_W-1)
//     CNT_W      width of each per-channel debounce counter
//   Ports
//     clk        single clock, rising edge
//     rst        synchronous active-high reset, highest priority
//     btn[3:0]   raw asynchronous button levels
//     db[3:0]    debounced level per channel
//     press[3:0] one-cycle pulse when db rises
//     rel[3:0]   one-cycle pulse when db falls ("release" is a reserved word)
//     tog[3:0]   inverts on every accepted press
//     press_cnt  accepted presses over all channels, modulo 256
module button_debounce #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [3:0] db,
  output logic [3:0] press,
  output logic [3:0] rel,
  output logic [3:0] tog,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {IDLE_LO, DEB_HI, IDLE_HI, DEB_LO} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam bit               SHORT    = (DB_CYCLES == 1);

  logic [3:0] s1;
  logic [3:0] s2;
  logic [3:0] rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             db_q;
    logic             press_q;
    logic             rel_q;
    logic             tog_q;

    // Same-edge view of "this channel commits a press", so press_cnt
    // advances on the edge that raises press rather than one cycle later.
    assign rise[i] = s2[i] & (((st == IDLE_LO) & SHORT) |
                              ((st == DEB_HI) & (cnt == CNT_LAST)));

    always_ff @(posedge clk) begin
      if (rst) begin
        st      <= IDLE_LO;
        cnt     <= '0;
        db_q    <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        tog_q   <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        case (st)
          IDLE_LO: begin
            if (s2[i]) begin
              if (SHORT) begin
                st      <= IDLE_HI;
                db_q    <= 1'b1;
                press_q <= 1'b1;
                tog_q   <= ~tog_q;
              end else begin
                st  <= DEB_HI;
                cnt <= CNT_W'(1);
              end
            end
          end
          DEB_HI: begin
            if (!s2[i]) begin
              st  <= IDLE_LO;
              cnt <= '0;
            end else if (cnt == CNT_LAST) begin
              st      <= IDLE_HI;
              cnt     <= '0;
              db_q    <= 1'b1;
              press_q <= 1'b1;
              tog_q   <= ~tog_q;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          IDLE_HI: begin
            if (!s2[i]) begin
              if (SHORT) begin
                st    <= IDLE_LO;
                db_q  <= 1'b0;
                rel_q <= 1'b1;
              end else begin
                st  <= DEB_LO;
                cnt <= CNT_W'(1);
              end
            end
          end
          DEB_LO: begin
            if (s2[i]) begin
              st  <= IDLE_HI;
              cnt <= '0;
            end else if (cnt == CNT_LAST) begin
              st    <= IDLE_LO;
              cnt   <= '0;
              db_q  <= 1'b0;
              rel_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            st  <= IDLE_LO;
            cnt <= '0;
          end
        endcase
      end
    end

    assign db[i]    = db_q;
    assign press[i] = press_q;
    assign rel[i]   = rel_q;
    assign tog[i]   = tog_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      press_cnt <= '0;
    end else begin
      press_cnt <= press_cnt + 8'($countones(rise));
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  localparam int DB = 4;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] db;
  logic [3:0] press;
  logic [3:0] rel;
  logic [3:0] tog;
  logic [7:0] press_cnt;

  button_debounce #(.DB_CYCLES(DB), .CNT_W(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .db        (db),
    .press     (press),
    .rel       (rel),
    .tog       (tog),
    .press_cnt (press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] db;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] tog;
    logic [7:0] pc;
  } obs_t;

  typedef struct {
    logic       r;
    logic [3:0] b;
    int         n;
    logic [3:0] edb;
    logic [3:0] etog;
    logic [7:0] epc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  obs_t exp_q[$];

  // reference model: run length of s2 disagreeing with the accepted level
  logic [3:0] m_s1, m_s2, m_db, m_tog, m_p, m_r;
  logic [7:0] m_pc;
  int         m_run[4];

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [3:0] b);
    m_p = '0;
    m_r = '0;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_tog = '0; m_pc = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_run[i] = 0;
            m_db[i]  = ~m_db[i];
            if (m_db[i]) begin
              m_p[i]   = 1'b1;
              m_tog[i] = ~m_tog[i];
            end else begin
              m_r[i] = 1'b1;
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_pc = m_pc + 8'($countones(m_p));
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  task automatic tick(input logic r, input logic [3:0] b);
    obs_t e;
    obs_t g;
    @(negedge clk);
    rst = r;
    btn = b;
    model_step(r, b);
    exp_q.push_back('{db: m_db, press: m_p, rel: m_r, tog: m_tog, pc: m_pc});
    @(posedge clk);
    #1;
    g = '{db: db, press: press, rel: rel, tog: tog, pc: press_cnt};
    e = exp_q.pop_front();
    check("scoreboard", 24'(g), 24'(e));
  endtask

  task automatic do_reset();
    tick(1'b1, 4'b0000);
    tick(1'b1, 4'b0000);
  endtask

  vec_t tbl[7];
  int   np, nr, first;

  initial begin
    tbl[0] = '{r: 1'b1, b: 4'b0000, n: 2,  edb: 4'b0000, etog: 4'b0000, epc: 8'd0};
    tbl[1] = '{r: 1'b0, b: 4'b0001, n: 20, edb: 4'b0001, etog: 4'b0001, epc: 8'd1};
    tbl[2] = '{r: 1'b0, b: 4'b0011, n: 3,  edb: 4'b0001, etog: 4'b0001, epc: 8'd1};
    tbl[3] = '{r: 1'b0, b: 4'b0001, n: 10, edb: 4'b0001, etog: 4'b0001, epc: 8'd1};
    tbl[4] = '{r: 1'b0, b: 4'b0000, n: 10, edb: 4'b0000, etog: 4'b0001, epc: 8'd1};
    tbl[5] = '{r: 1'b0, b: 4'b0001, n: 10, edb: 4'b0001, etog: 4'b0000, epc: 8'd2};
    tbl[6] = '{r: 1'b0, b: 4'b0000, n: 10, edb: 4'b0000, etog: 4'b0000, epc: 8'd2};

    rst = 1'b1;
    btn = 4'b0000;
    m_s1 = '0; m_s2 = '0; m_db = '0; m_tog = '0; m_pc = '0; m_p = '0; m_r = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;

    // hold btn[0]: db and press appear on edge 6 only
    do_reset();
    check("reset_state", 24'({db, press, rel, tog, press_cnt}), 24'(0));
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, 4'b0001);
      check("db0_edge", 24'(db[0]), 24'(k >= 6));
      check("press0_edge", 24'(press[0]), 24'(k == 6));
    end
    check("hold_tog", 24'(tog), 24'(4'b0001));
    check("hold_cnt", 24'(press_cnt), 24'(8'd1));

    // table: short pulse rejection, release, second press toggles back
    for (int v = 0; v < 7; v++) begin
      for (int c = 0; c < tbl[v].n; c++) tick(tbl[v].r, tbl[v].b);
      check("tbl_db", 24'(db), 24'(tbl[v].edb));
      check("tbl_tog", 24'(tog), 24'(tbl[v].etog));
      check("tbl_cnt", 24'(press_cnt), 24'(tbl[v].epc));
    end

    // bouncing btn[2]
    do_reset();
    np = 0;
    nr = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, ((k / 2) % 2 == 0) ? 4'b0100 : 4'b0000);
      np += int'(press[2]);
      nr += int'(rel[2]);
    end
    check("bounce_no_press", 24'(np), 24'(0));
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 4'b0100);
      np += int'(press[2]);
      nr += int'(rel[2]);
    end
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 4'b0000);
      np += int'(press[2]);
      nr += int'(rel[2]);
    end
    check("bounce_presses", 24'(np), 24'(1));
    check("bounce_releases", 24'(nr), 24'(1));
    check("bounce_tog", 24'(tog), 24'(4'b0100));

    // drive press_cnt to 254 with every toggle even, then all four at once
    do_reset();
    for (int k = 0; k < 62; k++) begin
      for (int c = 0; c < 8; c++) tick(1'b0, 4'b1111);
      for (int c = 0; c < 8; c++) tick(1'b0, 4'b0000);
    end
    for (int ch = 0; ch < 3; ch++) begin
      for (int rep = 0; rep < 2; rep++) begin
        for (int c = 0; c < 8; c++) tick(1'b0, 4'b0001 << ch);
        for (int c = 0; c < 8; c++) tick(1'b0, 4'b0000);
      end
    end
    check("pre_wrap_cnt", 24'(press_cnt), 24'(8'd254));
    check("pre_wrap_tog", 24'(tog), 24'(4'b0000));
    for (int c = 0; c < 5; c++) tick(1'b0, 4'b1111);
    check("wrap_before", 24'(press), 24'(4'b0000));
    tick(1'b0, 4'b1111);
    check("wrap_press", 24'(press), 24'(4'b1111));
    check("wrap_cnt", 24'(press_cnt), 24'(8'd2));
    check("wrap_tog", 24'(tog), 24'(4'b1111));
    tick(1'b0, 4'b1111);
    check("wrap_after", 24'(press), 24'(4'b0000));
    check("wrap_cnt_hold", 24'(press_cnt), 24'(8'd2));

    // reset at debounce count 3 of btn[3], button kept held
    do_reset();
    for (int c = 0; c < 5; c++) tick(1'b0, 4'b1000);
    tick(1'b1, 4'b1000);
    check("rst_mid_press", 24'(press), 24'(4'b0000));
    check("rst_mid_db", 24'(db), 24'(4'b0000));
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, 4'b1000);
      if (press[3] && first < 0) first = k;
    end
    check("rst_press_edge", 24'(first), 24'(6));
    check("rst_press_cnt", 24'(press_cnt), 24'(8'd1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 16: consecutive synchronized cycles an input must hold a new level before acceptance; legal range 1 to 2^CNT_W-1.
REQ-002 The block SHALL have parameter CNT_W, default 20: width of each per-channel debounce counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change only on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port btn, input, 4 bits: raw asynchronous, bouncing push-button levels, channel i = btn[i].
REQ-006 The block SHALL have port db, output, 4 bits: debounced stable level per channel.
REQ-007 The block SHALL have port press, output, 4 bits: one-cycle pulse when db[i] rises.
REQ-008 The block SHALL have port release, output, 4 bits: one-cycle pulse when db[i] falls.
REQ-009 The block SHALL have port tog, output, 4 bits: per-channel toggle that inverts on each accepted press, used to drive LEDs.
REQ-010 The block SHALL have port press_cnt, output, 8 bits: total accepted presses over all channels, modulo 256.

Function
REQ-011 Each channel SHALL pass btn[i] through a two-flop synchronizer (s1, s2) before any other logic uses it.
REQ-012 Each channel SHALL run an independent FSM with states IDLE_LO, DEB_HI, IDLE_HI and DEB_LO.
REQ-013 From IDLE_LO, s2=1 SHALL move the FSM to DEB_HI with cnt<=1; when DB_CYCLES=1 the channel SHALL instead commit directly to IDLE_HI.
REQ-014 In DEB_HI, s2=0 SHALL return the FSM to IDLE_LO with cnt<=0 and no output change.
REQ-015 In DEB_HI, s2=1 with cnt=DB_CYCLES-1 SHALL commit to IDLE_HI; otherwise s2=1 SHALL increment cnt.
REQ-016 IDLE_HI and DEB_LO SHALL behave as the mirror image of IDLE_LO and DEB_HI, with the polarity of s2 inverted.
REQ-017 Committing to IDLE_HI SHALL, on the same edge, set db[i]=1, assert press[i] for exactly one cycle and invert tog[i].
REQ-018 Committing to IDLE_LO from DEB_LO SHALL, on the same edge, set db[i]=0 and assert release[i] for exactly one cycle; tog[i] SHALL NOT change.
REQ-019 Latency: if btn[i] changes and holds, db[i] SHALL update on the (DB_CYCLES+2)th rising edge, counting the first edge that samples the new level as edge 1.
REQ-020 Any reversal of s2 before acceptance SHALL abort the debounce without producing a pulse; a bouncing input SHALL therefore produce exactly one press or release per settled transition.
REQ-021 press and release SHALL never both be asserted for the same channel in the same cycle.
REQ-022 A single pulse SHALL NOT last more than one cycle, even while the input stays held.
REQ-023 press_cnt SHALL add, on the same edge press is asserted, the number of press bits asserted (0-4).
REQ-024 press_cnt SHALL wrap modulo 256 (e.g. 254 + 4 = 2).
REQ-025 All outputs SHALL be registered, with no combinational path from btn to any output.
REQ-026 Channels SHALL NOT interact except through press_cnt.

Reset
REQ-027 While rst=1 at a rising edge, s1, s2, cnt, db, press, release, tog and press_cnt SHALL all become 0, and every FSM SHALL enter IDLE_LO.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count and emit no pulse.
REQ-029 After reset deasserts, a button already held high SHALL be treated as a new press, requiring the full latency before acceptance.
REQ-030 rst SHALL take priority over all other activity on the same edge.

Verification (DB_CYCLES=4)
REQ-031 Hold btn[0]=1 for 20 cycles after reset -> db[0]=1 on edge 6, press[0] high for that one cycle only, tog[0]=1, press_cnt=1.
REQ-032 Pulse btn[1] high for 3 cycles, then low -> db, press, tog and press_cnt all unchanged.
REQ-033 Toggle btn[2] every 2 cycles for 12 cycles, then hold 1 for 10 cycles, then hold 0 for 10 cycles -> exactly one press[2] and one release[2]; tog[2]=1.
REQ-034 Raise all four btn bits simultaneously with press_cnt=254 -> press=4'b1111 for one cycle, press_cnt=2, tog=4'b1111.
REQ-035 Assert rst at debounce count 3 of btn[3], then deassert with btn[3] still held -> no pulse during reset; press[3] fires 6 edges after rst deasserts.
REQ-036 Press, release and press btn[0] again, each held 10 cycles -> tog[0] reads 1, then 0 after the second press, with one release[0] between the two presses.
